// File: rtl/dmem_resp.sv
// dmem_resp: word-organised data RAM slave for the load/store path, with byte-lane writes and fault detection.
// Latency: cs_i sampled at edge N gives mem_ready_o in cycle N+1+WAIT_CYC; at most one request per WAIT_CYC+2 cycles.
// Backpressure: cs_i is sampled only in IDLE; the requester holds its fields until the one-cycle mem_ready_o pulse.
module dmem_resp #(
  parameter int ADDR_W   = 12,
  parameter int WAIT_CYC = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cs_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_wem_i,
  input  logic [31:0] mem_din_i,
  input  logic [31:0] mem_addr_i,
  output logic        mem_ready_o,
  output logic        mem_rvalid_o,
  output logic [31:0] mem_dout_o,
  output logic        mem_err_o,
  output logic        busy_o
);

  localparam int         DEPTH   = 1 << ADDR_W;
  localparam bit         NO_WAIT = (WAIT_CYC == 0);
  localparam logic [3:0] WAIT_LD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [3:0]  wem_q;
  logic [31:0] din_q;
  logic [31:0] addr_q;

  logic [31:0] mem [DEPTH];

  // Fields used by the array access: with no wait states the access happens on
  // the accept edge itself, so the live inputs are used instead of the latch.
  logic              in_idle;
  logic              go_resp;
  logic              acc_we;
  logic [3:0]        acc_wem;
  logic [31:0]       acc_din;
  logic [31:0]       acc_addr;
  logic              fault;
  logic [ADDR_W-1:0] widx;

  // Select access fields and detect the edge that enters RESP
  always_comb begin
    in_idle  = (state == S_IDLE);
    acc_we   = in_idle ? mem_we_i   : we_q;
    acc_wem  = in_idle ? mem_wem_i  : wem_q;
    acc_din  = in_idle ? mem_din_i  : din_q;
    acc_addr = in_idle ? mem_addr_i : addr_q;
    // rstn gates the RAM port, which has no reset of its own
    go_resp  = rstn && ((NO_WAIT && in_idle && cs_i) || ((state == S_WAIT) && (cnt == 4'd0)));
    fault    = (|acc_addr[1:0]) || (|acc_addr[31:ADDR_W+2]);
    widx     = acc_addr[ADDR_W+1:2];
  end

  // Byte-lane write into the array on entry to RESP; faulted requests never write
  always_ff @(posedge clk) begin
    if (go_resp && acc_we && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_wem[b]) mem[widx][8*b +: 8] <= acc_din[8*b +: 8];
      end
    end
  end

  // Request FSM with registered response outputs and read-data capture
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      we_q         <= 1'b0;
      wem_q        <= 4'd0;
      din_q        <= 32'd0;
      addr_q       <= 32'd0;
      mem_ready_o  <= 1'b0;
      mem_rvalid_o <= 1'b0;
      mem_err_o    <= 1'b0;
      mem_dout_o   <= 32'd0;
      busy_o       <= 1'b0;
    end else begin
      mem_ready_o  <= 1'b0;
      mem_rvalid_o <= 1'b0;
      mem_err_o    <= 1'b0;
      if (go_resp) begin
        mem_ready_o  <= 1'b1;
        mem_rvalid_o <= !acc_we && !fault;
        mem_err_o    <= fault;
        if (!acc_we && !fault) mem_dout_o <= mem[widx];
      end
      case (state)
        S_IDLE: begin
          if (cs_i) begin
            we_q   <= mem_we_i;
            wem_q  <= mem_wem_i;
            din_q  <= mem_din_i;
            addr_q <= mem_addr_i;
            busy_o <= 1'b1;
            if (NO_WAIT) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= WAIT_LD;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        S_RESP: begin
          // cs_i is ignored here; the next request is sampled back in IDLE
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: directed checks of dmem_resp across four wait-state configurations.
// Instances: 0 -> WAIT_CYC=0, 1 -> WAIT_CYC=1, 2 -> WAIT_CYC=5, 3 -> WAIT_CYC=4.
// Each request waits a bounded number of cycles for mem_ready_o.
module tb_dmem_resp;

  logic        clk;
  logic        rstn_a   [4];
  logic        cs       [4];
  logic        we_a     [4];
  logic [3:0]  wem      [4];
  logic [31:0] din      [4];
  logic [31:0] addr     [4];
  logic        ready    [4];
  logic        rvalid   [4];
  logic [31:0] dout     [4];
  logic        err      [4];
  logic        busy     [4];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_resp #(.ADDR_W(12), .WAIT_CYC(0)) u_dut0 (
    .clk(clk), .rstn(rstn_a[0]), .cs_i(cs[0]), .mem_we_i(we_a[0]), .mem_wem_i(wem[0]),
    .mem_din_i(din[0]), .mem_addr_i(addr[0]), .mem_ready_o(ready[0]), .mem_rvalid_o(rvalid[0]),
    .mem_dout_o(dout[0]), .mem_err_o(err[0]), .busy_o(busy[0]));

  dmem_resp #(.ADDR_W(12), .WAIT_CYC(1)) u_dut1 (
    .clk(clk), .rstn(rstn_a[1]), .cs_i(cs[1]), .mem_we_i(we_a[1]), .mem_wem_i(wem[1]),
    .mem_din_i(din[1]), .mem_addr_i(addr[1]), .mem_ready_o(ready[1]), .mem_rvalid_o(rvalid[1]),
    .mem_dout_o(dout[1]), .mem_err_o(err[1]), .busy_o(busy[1]));

  dmem_resp #(.ADDR_W(12), .WAIT_CYC(5)) u_dut5 (
    .clk(clk), .rstn(rstn_a[2]), .cs_i(cs[2]), .mem_we_i(we_a[2]), .mem_wem_i(wem[2]),
    .mem_din_i(din[2]), .mem_addr_i(addr[2]), .mem_ready_o(ready[2]), .mem_rvalid_o(rvalid[2]),
    .mem_dout_o(dout[2]), .mem_err_o(err[2]), .busy_o(busy[2]));

  dmem_resp #(.ADDR_W(12), .WAIT_CYC(4)) u_dut4 (
    .clk(clk), .rstn(rstn_a[3]), .cs_i(cs[3]), .mem_we_i(we_a[3]), .mem_wem_i(wem[3]),
    .mem_din_i(din[3]), .mem_addr_i(addr[3]), .mem_ready_o(ready[3]), .mem_rvalid_o(rvalid[3]),
    .mem_dout_o(dout[3]), .mem_err_o(err[3]), .busy_o(busy[3]));

  // Issue one request on instance i and wait for its response.
  // lat counts samples taken #1 after each edge, starting at 1 right after the
  // accept edge; -1 means no ready pulse within the budget.
  task automatic do_req(input int i, input logic w, input logic [3:0] m, input logic [31:0] d,
                        input logic [31:0] a, output int lat, output logic rv, output logic er,
                        output logic [31:0] q, output logic busy_ok);
    lat = -1; rv = 1'b0; er = 1'b0; q = 32'd0; busy_ok = 1'b1;
    @(negedge clk);
    cs[i] = 1'b1; we_a[i] = w; wem[i] = m; din[i] = d; addr[i] = a;
    @(posedge clk);
    for (int j = 1; j <= 40; j++) begin
      #1;
      if (busy[i] !== 1'b1) busy_ok = 1'b0;
      if (ready[i] === 1'b1) begin
        lat = j; rv = rvalid[i]; er = err[i]; q = dout[i];
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
    cs[i] = 1'b0; we_a[i] = 1'b0; wem[i] = 4'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({ready[i], rvalid[i], err[i], busy[i], dout[i]} !== 36'd0) begin
        n_fail++;
        $display("FAIL reset_outputs inst%0d: got rdy=%b rv=%b err=%b busy=%b dout=%h, want all 0",
                 i, ready[i], rvalid[i], err[i], busy[i], dout[i]);
      end
    end
  endtask

  task automatic test_word_rw();
    int lat; logic rv, er, bo; logic [31:0] q;
    do_req(1, 1'b1, 4'hF, 32'hDEADBEEF, 32'h10, lat, rv, er, q, bo);
    n_checks++;
    if (lat !== 2 || er !== 1'b0 || rv !== 1'b0) begin
      n_fail++;
      $display("FAIL word_write: got lat=%0d err=%b rv=%b, want lat=2 err=0 rv=0", lat, er, rv);
    end
    do_req(1, 1'b0, 4'h0, 32'h0, 32'h10, lat, rv, er, q, bo);
    n_checks++;
    if (lat !== 2 || rv !== 1'b1 || er !== 1'b0 || q !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL word_read: got lat=%0d rv=%b err=%b dout=%h, want lat=2 rv=1 err=0 dout=deadbeef",
               lat, rv, er, q);
    end
  endtask

  task automatic test_byte_lane();
    int lat; logic rv, er, bo; logic [31:0] q;
    do_req(1, 1'b1, 4'b0101, 32'h11223344, 32'h10, lat, rv, er, q, bo);
    do_req(1, 1'b0, 4'h0, 32'h0, 32'h10, lat, rv, er, q, bo);
    n_checks++;
    if (rv !== 1'b1 || q !== 32'hDE22BE44) begin
      n_fail++;
      $display("FAIL byte_lane: got rv=%b dout=%h, want rv=1 dout=de22be44", rv, q);
    end
  endtask

  task automatic test_faults();
    int lat; logic rv, er, bo; logic [31:0] q;
    do_req(1, 1'b0, 4'h0, 32'h0, 32'h12, lat, rv, er, q, bo);
    n_checks++;
    if (lat !== 2 || er !== 1'b1 || rv !== 1'b0 || q !== 32'hDE22BE44) begin
      n_fail++;
      $display("FAIL misaligned_read: got lat=%0d err=%b rv=%b dout=%h, want lat=2 err=1 rv=0 dout=de22be44",
               lat, er, rv, q);
    end
    do_req(1, 1'b1, 4'hF, 32'hCAFEF00D, 32'h0, lat, rv, er, q, bo);
    do_req(1, 1'b1, 4'hF, 32'h55555555, 32'h4000, lat, rv, er, q, bo);
    n_checks++;
    if (lat !== 2 || er !== 1'b1 || rv !== 1'b0) begin
      n_fail++;
      $display("FAIL range_write: got lat=%0d err=%b rv=%b, want lat=2 err=1 rv=0", lat, er, rv);
    end
    do_req(1, 1'b0, 4'h0, 32'h0, 32'h0, lat, rv, er, q, bo);
    n_checks++;
    if (rv !== 1'b1 || q !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL range_no_alias: got rv=%b dout=%h, want rv=1 dout=cafef00d", rv, q);
    end
  endtask

  task automatic test_noop_write();
    int lat; logic rv, er, bo; logic [31:0] q;
    do_req(1, 1'b1, 4'h0, 32'hFFFFFFFF, 32'h10, lat, rv, er, q, bo);
    n_checks++;
    if (lat !== 2 || er !== 1'b0 || rv !== 1'b0) begin
      n_fail++;
      $display("FAIL noop_write: got lat=%0d err=%b rv=%b, want lat=2 err=0 rv=0", lat, er, rv);
    end
    do_req(1, 1'b0, 4'h0, 32'h0, 32'h10, lat, rv, er, q, bo);
    n_checks++;
    if (q !== 32'hDE22BE44) begin
      n_fail++;
      $display("FAIL noop_readback: got dout=%h, want de22be44", q);
    end
  endtask

  task automatic test_latency(input int i, input int exp_lat);
    int lat; logic rv, er, bo; logic [31:0] q;
    do_req(i, 1'b1, 4'hF, 32'h0BADF00D, 32'h10, lat, rv, er, q, bo);
    n_checks++;
    if (lat !== exp_lat || bo !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_write inst%0d: got lat=%0d busy_held=%b, want lat=%0d busy_held=1",
               i, lat, bo, exp_lat);
    end
    do_req(i, 1'b0, 4'h0, 32'h0, 32'h10, lat, rv, er, q, bo);
    n_checks++;
    if (lat !== exp_lat || bo !== 1'b1 || q !== 32'h0BADF00D) begin
      n_fail++;
      $display("FAIL latency_read inst%0d: got lat=%0d busy_held=%b dout=%h, want lat=%0d busy_held=1 dout=0badf00d",
               i, lat, bo, q, exp_lat);
    end
    n_checks++;
    if (busy[i] !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_release inst%0d: got busy=%b, want 0", i, busy[i]);
    end
  endtask

  task automatic test_back_to_back(input int i, input int exp_gap);
    int t [3];
    int k = 0;
    @(negedge clk);
    cs[i] = 1'b1; we_a[i] = 1'b0; wem[i] = 4'h0; addr[i] = 32'h10;
    for (int c = 0; c < 60 && k < 3; c++) begin
      @(posedge clk); #1;
      if (ready[i] === 1'b1) begin
        t[k] = c; k++;
      end
    end
    @(negedge clk);
    cs[i] = 1'b0;
    repeat (exp_gap + 2) @(posedge clk);
    #1;
    n_checks++;
    if (k != 3) begin
      n_fail++;
      $display("FAIL b2b_count inst%0d: got %0d responses, want 3", i, k);
    end else begin
      n_checks++;
      if (t[1] - t[0] != exp_gap) begin
        n_fail++;
        $display("FAIL b2b_gap1 inst%0d: got %0d, want %0d", i, t[1] - t[0], exp_gap);
      end
      n_checks++;
      if (t[2] - t[1] != exp_gap) begin
        n_fail++;
        $display("FAIL b2b_gap2 inst%0d: got %0d, want %0d", i, t[2] - t[1], exp_gap);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int lat; logic rv, er, bo; logic [31:0] q;
    logic seen;
    do_req(3, 1'b1, 4'hF, 32'h12345678, 32'h20, lat, rv, er, q, bo);
    n_checks++;
    if (lat !== 5) begin
      n_fail++;
      $display("FAIL wait4_latency: got lat=%0d, want 5", lat);
    end
    do_req(3, 1'b0, 4'h0, 32'h0, 32'h20, lat, rv, er, q, bo);
    @(negedge clk);
    cs[3] = 1'b1; we_a[3] = 1'b1; wem[3] = 4'hF; din[3] = 32'hA5A5A5A5; addr[3] = 32'h20;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #2;
    rstn_a[3] = 1'b0;
    cs[3] = 1'b0;
    #1;
    n_checks++;
    if ({ready[3], rvalid[3], err[3], busy[3], dout[3]} !== 36'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got rdy=%b rv=%b err=%b busy=%b dout=%h, want all 0",
               ready[3], rvalid[3], err[3], busy[3], dout[3]);
    end
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ready[3] !== 1'b0) seen = 1'b1;
    end
    @(negedge clk);
    rstn_a[3] = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (ready[3] !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_no_ready: got ready pulse=%b, want 0", seen);
    end
    do_req(3, 1'b0, 4'h0, 32'h0, 32'h20, lat, rv, er, q, bo);
    n_checks++;
    if (lat !== 5 || rv !== 1'b1 || q !== 32'h12345678) begin
      n_fail++;
      $display("FAIL mid_reset_readback: got lat=%0d rv=%b dout=%h, want lat=5 rv=1 dout=12345678",
               lat, rv, q);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rstn_a[i] = 1'b0; cs[i] = 1'b0; we_a[i] = 1'b0; wem[i] = 4'd0;
      din[i] = 32'd0; addr[i] = 32'd0;
    end
    #12;
    test_reset();
    #10;
    for (int i = 0; i < 4; i++) rstn_a[i] = 1'b1;
    repeat (2) @(posedge clk);
    test_word_rw();
    test_byte_lane();
    test_faults();
    test_noop_write();
    test_latency(0, 1);
    test_latency(2, 6);
    test_back_to_back(0, 2);
    test_back_to_back(2, 7);
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
